// File: rtl/rk4_step_controller_pkg.sv
// Shared types and defaults for the RK4 step sequencer.
// State encoding plus the default Q16.16 data format.
package rk4_step_controller_pkg;

  localparam int DEF_N    = 32;
  localparam int DEF_FRAC = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_K1   = 3'd1,
    ST_K2   = 3'd2,
    ST_K3   = 3'd3,
    ST_K4   = 3'd4,
    ST_ACC  = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  function automatic logic is_k_state(input state_t s);
    return (s == ST_K1) || (s == ST_K2) || (s == ST_K3) || (s == ST_K4);
  endfunction

endpackage

// File: rtl/rk4_step_controller_fxp_mul.sv
// Signed fixed-point multiply: full 2n-bit product, arithmetic shift by FRAC,
// low n bits kept (wraps on overflow).
module fxp_mul #(
  parameter int n    = 32,
  parameter int FRAC = 16
) (
  input  logic signed [n-1:0] a,
  input  logic signed [n-1:0] b,
  output logic signed [n-1:0] p
);

  logic signed [2*n-1:0] a_ext;
  logic signed [2*n-1:0] b_ext;
  logic signed [2*n-1:0] full;

  assign a_ext = {{n{a[n-1]}}, a};
  assign b_ext = {{n{b[n-1]}}, b};
  assign full  = a_ext * b_ext;
  assign p     = n'(full >>> FRAC);

endmodule

// File: rtl/rk4_step_controller.sv
// RK4 step sequencer: drives an external dy/dx evaluator four times per step,
// accumulates k1..k4 and reports each (x, y) result with a one-cycle pulse.
module rk4_step_controller
  import rk4_step_controller_pkg::*;
#(
  parameter int n       = DEF_N,
  parameter int FRAC    = DEF_FRAC,
  parameter int FN_WAIT = 1,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [n-1:0] x0,
  input  logic signed [n-1:0] y0,
  input  logic signed [n-1:0] h,
  input  logic [CNT_W-1:0]    n_steps,
  output logic                busy,
  output logic                step_valid,
  output logic signed [n-1:0] x_out,
  output logic signed [n-1:0] y_out,
  output logic                done,
  output logic signed [n-1:0] fx_x,
  output logic signed [n-1:0] fx_y,
  output logic signed [n-1:0] fx_h,
  output logic signed [n-1:0] fx_k,
  input  logic signed [n-1:0] fx_dydx
);

  localparam int WAIT_W = (FN_WAIT < 1) ? 1 : $clog2(FN_WAIT + 1);
  localparam int SW     = n + 3;
  localparam logic signed [SW-1:0] SIX = SW'(6);

  state_t state_reg;
  state_t state_next;

  logic signed [n-1:0] x_reg;
  logic signed [n-1:0] y_reg;
  logic signed [n-1:0] h_reg;
  logic [CNT_W-1:0]    steps_reg;
  logic                zero_run_reg;
  logic [WAIT_W-1:0]   wait_reg;
  logic signed [n-1:0] k1_reg;
  logic signed [n-1:0] k2_reg;
  logic signed [n-1:0] k3_reg;
  logic signed [n-1:0] k4_reg;
  logic signed [n-1:0] fx_x_reg;
  logic signed [n-1:0] fx_y_reg;
  logic signed [n-1:0] fx_h_reg;
  logic signed [n-1:0] fx_k_reg;
  logic signed [n-1:0] x_out_reg;
  logic signed [n-1:0] y_out_reg;

  logic                wait_done;
  logic                last_step;
  logic signed [n-1:0] prod;
  logic signed [SW-1:0] s_sum;
  logic signed [n-1:0] x_acc;
  logic signed [n-1:0] y_acc;

  // One multiplier serves all four slope evaluations: kn = h * dy/dx.
  fxp_mul #(
    .n    (n),
    .FRAC (FRAC)
  ) u_mul (
    .a (h_reg),
    .b (fx_dydx),
    .p (prod)
  );

  assign wait_done = is_k_state(state_reg) && (wait_reg == WAIT_W'(FN_WAIT));
  assign last_step = (steps_reg == '0);

  assign s_sum = SW'(k1_reg) + (SW'(k2_reg) <<< 1) + (SW'(k3_reg) <<< 1) + SW'(k4_reg);
  assign x_acc = x_reg + h_reg;
  // Signed divide truncates toward zero, which is the required rounding.
  assign y_acc = y_reg + n'(s_sum / SIX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (n_steps == '0) ? ST_FIN : ST_K1;
        end
      end
      ST_K1:   if (wait_done) state_next = ST_K2;
      ST_K2:   if (wait_done) state_next = ST_K3;
      ST_K3:   if (wait_done) state_next = ST_K4;
      ST_K4:   if (wait_done) state_next = ST_ACC;
      ST_ACC:  state_next = ST_FIN;
      ST_FIN:  state_next = last_step ? ST_IDLE : ST_K1;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode; FIN is the reporting cycle of every step.
  always_comb begin
    busy       = 1'b0;
    step_valid = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy = 1'b0;
      end
      ST_FIN: begin
        step_valid = !zero_run_reg;
        done       = last_step;
        busy       = !last_step;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  // Datapath: operand registers, slope capture and accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_reg        <= '0;
      y_reg        <= '0;
      h_reg        <= '0;
      steps_reg    <= '0;
      zero_run_reg <= 1'b0;
      wait_reg     <= '0;
      k1_reg       <= '0;
      k2_reg       <= '0;
      k3_reg       <= '0;
      k4_reg       <= '0;
      fx_x_reg     <= '0;
      fx_y_reg     <= '0;
      fx_h_reg     <= '0;
      fx_k_reg     <= '0;
      x_out_reg    <= '0;
      y_out_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          wait_reg <= '0;
          if (start) begin
            x_reg        <= x0;
            y_reg        <= y0;
            h_reg        <= h;
            steps_reg    <= n_steps;
            zero_run_reg <= (n_steps == '0);
            if (n_steps == '0) begin
              x_out_reg <= x0;
              y_out_reg <= y0;
            end else begin
              fx_x_reg <= x0;
              fx_y_reg <= y0;
              fx_h_reg <= '0;
              fx_k_reg <= '0;
            end
          end
        end
        ST_K1, ST_K2, ST_K3, ST_K4: begin
          if (wait_done) begin
            wait_reg <= '0;
            // The next operand set is formed from the product captured this edge.
            case (state_reg)
              ST_K1: begin
                k1_reg   <= prod;
                fx_h_reg <= h_reg >>> 1;
                fx_k_reg <= prod >>> 1;
              end
              ST_K2: begin
                k2_reg   <= prod;
                fx_h_reg <= h_reg >>> 1;
                fx_k_reg <= prod >>> 1;
              end
              ST_K3: begin
                k3_reg   <= prod;
                fx_h_reg <= h_reg;
                fx_k_reg <= prod;
              end
              default: begin
                k4_reg <= prod;
              end
            endcase
          end else begin
            wait_reg <= wait_reg + WAIT_W'(1);
          end
        end
        ST_ACC: begin
          x_reg     <= x_acc;
          y_reg     <= y_acc;
          x_out_reg <= x_acc;
          y_out_reg <= y_acc;
          steps_reg <= steps_reg - CNT_W'(1);
        end
        ST_FIN: begin
          if (!last_step) begin
            fx_x_reg <= x_reg;
            fx_y_reg <= y_reg;
            fx_h_reg <= '0;
            fx_k_reg <= '0;
          end
        end
        default: begin
          wait_reg <= '0;
        end
      endcase
    end
  end

  assign x_out = x_out_reg;
  assign y_out = y_out_reg;
  assign fx_x  = fx_x_reg;
  assign fx_y  = fx_y_reg;
  assign fx_h  = fx_h_reg;
  assign fx_k  = fx_k_reg;

endmodule
